// File: rtl/ws281x_pkg.sv
// Shared WS281x definitions: detector FSM states, default line timing and counter helpers.
package ws281x_pkg;

  localparam int unsigned CNT_W            = 16;
  localparam int unsigned DEF_RST_CYC      = 5000;
  localparam int unsigned DEF_GLITCH_CYC   = 10;
  localparam int unsigned DEF_HIGH_MAX_CYC = 200;
  localparam int unsigned DEF_MIN_BITS     = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } det_state_t;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws281x_frame_detect_sync_edge.sv
// Two-flop synchroniser plus edge register; rise/fall are combinational from the last two stages.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/ws281x_frame_detect.sv
// Decodes WS281x bit periods on the strip data line and pulses once per valid latched frame.
module ws281x_frame_detect
  import ws281x_pkg::*;
#(
  parameter int unsigned RST_CYC      = DEF_RST_CYC,
  parameter int unsigned GLITCH_CYC   = DEF_GLITCH_CYC,
  parameter int unsigned HIGH_MAX_CYC = DEF_HIGH_MAX_CYC,
  parameter int unsigned MIN_BITS     = DEF_MIN_BITS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bit_i,
  input  logic        clr_i,
  output logic        pulse_o,
  output logic [15:0] bit_cnt_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] RST_LIM    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] GLITCH_LIM = CNT_W'(GLITCH_CYC);
  localparam logic [CNT_W-1:0] HIGH_LIM   = CNT_W'(HIGH_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LIM    = CNT_W'(MIN_BITS);

  logic rise_c, fall_c;

  sync_edge u_sync_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (bit_i),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  det_state_t       state_q, state_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             pulse_q, pulse_d;
  logic             err_q, err_d;
  logic             set_err_c;

  // Next-state: phase timing, bit acceptance and frame end decision.
  always_comb begin
    state_d   = state_q;
    width_d   = sat_inc(width_q);
    bits_d    = bits_q;
    bit_cnt_d = bit_cnt_q;
    pulse_d   = 1'b0;
    set_err_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        width_d = width_q;
        bits_d  = '0;
        if (rise_c) begin
          state_d = HIGH;
          width_d = CNT_W'(1);
        end
      end
      HIGH: begin
        if (fall_c) begin
          state_d = LOW;
          width_d = CNT_W'(1);
          if (width_q >= GLITCH_LIM) bits_d = sat_inc(bits_q);
          else                       set_err_c = 1'b1;
        end else if (width_q == HIGH_LIM) begin
          state_d   = STUCK;
          set_err_c = 1'b1;
        end
      end
      LOW: begin
        // Frame end has priority over a coincident rise; that bit is lost.
        if (width_q == RST_LIM) begin
          if (bits_q >= MIN_LIM) begin
            pulse_d   = 1'b1;
            bit_cnt_d = bits_q;
          end else begin
            set_err_c = 1'b1;
          end
          bits_d  = '0;
          width_d = '0;
          state_d = IDLE;
        end else if (rise_c) begin
          state_d = HIGH;
          width_d = CNT_W'(1);
        end
      end
      STUCK: begin
        width_d = width_q;
        if (fall_c) begin
          bits_d  = '0;
          width_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = clr_i ? 1'b0 : err_q;
    if (set_err_c) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      width_q   <= '0;
      bits_q    <= '0;
      bit_cnt_q <= '0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      bits_q    <= bits_d;
      bit_cnt_q <= bit_cnt_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign bit_cnt_o = bit_cnt_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ws281x_frame_detect.sv
// Bench for ws281x_frame_detect: directed frame table, hand corner cases and random frames vs a phase-level model.
module tb_ws281x_frame_detect;

  localparam int RST_CYC      = 400;
  localparam int GLITCH_CYC   = 10;
  localparam int HIGH_MAX_CYC = 200;
  localparam int MIN_BITS     = 24;

  logic        clk = 1'b0;
  logic        rst_i, bit_i, clr_i;
  logic        pulse_o, err_o;
  logic [15:0] bit_cnt_o;

  always #5 clk = ~clk;

  ws281x_frame_detect #(
    .RST_CYC      (RST_CYC),
    .GLITCH_CYC   (GLITCH_CYC),
    .HIGH_MAX_CYC (HIGH_MAX_CYC),
    .MIN_BITS     (MIN_BITS)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .bit_i     (bit_i),
    .clr_i     (clr_i),
    .pulse_o   (pulse_o),
    .bit_cnt_o (bit_cnt_o),
    .err_o     (err_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulses observed on the DUT, stamped with the posedge count.
  int got_cyc[$];
  int got_cnt[$];
  int n_pulse = 0;
  always @(negedge clk) begin
    if (pulse_o) begin
      got_cyc.push_back(cyc);
      got_cnt.push_back(int'(bit_cnt_o));
      n_pulse <= n_pulse + 1;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model working on whole line phases (level, length in clocks).
  int m_bits = 0;
  int m_last = 0;
  bit m_err  = 1'b0;
  bit m_in   = 1'b0;
  bit m_drop = 1'b0;
  int exp_cyc[$];
  int exp_cnt[$];

  task automatic model_phase(input logic lvl, input int n);
    if (lvl) begin
      if (m_drop) m_drop = 1'b0;
      else if (n >= HIGH_MAX_CYC) begin
        m_err = 1'b1; m_bits = 0; m_in = 1'b0;
      end else begin
        m_in = 1'b1;
        if (n < GLITCH_CYC) m_err = 1'b1;
        else if (m_bits < 65535) m_bits++;
      end
    end else if (m_in && n >= RST_CYC - 1) begin
      if (m_bits >= MIN_BITS) begin
        exp_cyc.push_back(cyc + RST_CYC + 2);
        exp_cnt.push_back(m_bits);
        m_last = m_bits;
      end else begin
        m_err = 1'b1;
      end
      m_bits = 0;
      m_in   = 1'b0;
      m_drop = (n == RST_CYC - 1);
    end
  endtask

  task automatic phase(input logic lvl, input int n);
    model_phase(lvl, n);
    bit_i = lvl;
    repeat (n) @(negedge clk);
  endtask

  // gap = 0 leaves the final low to the caller.
  task automatic send_frame(input int nbits, input int hi, input int lo, input int gap, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) begin
        phase(1'b1, 5);
        phase(1'b0, lo);
      end
      phase(1'b1, hi);
      if (i < nbits - 1)  phase(1'b0, lo);
      else if (gap > 0)   phase(1'b0, gap);
    end
  endtask

  task automatic do_clr();
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_pulses(input string name);
    while (got_cyc.size() > 0 && exp_cyc.size() > 0) begin
      chk({name, "_pulse_cycle"}, got_cyc.pop_front(), exp_cyc.pop_front());
      chk({name, "_pulse_cnt"}, got_cnt.pop_front(), exp_cnt.pop_front());
    end
    chk({name, "_extra_pulses"}, got_cyc.size(), exp_cyc.size());
    got_cyc.delete(); got_cnt.delete(); exp_cyc.delete(); exp_cnt.delete();
    chk({name, "_bit_cnt"}, int'(bit_cnt_o), m_last);
    chk({name, "_err"}, int'(err_o), int'(m_err));
  endtask

  typedef struct {
    int nbits;
    int hi;
    int lo;
    int glitch_at;
    int exp_pulses;
    int exp_cnt;
    int exp_err;
    bit do_clr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n0, c;
    tbl[0] = '{24,  40, 85, -1, 1, 24, 0, 1'b0};  // nominal frame
    tbl[1] = '{ 8,  40, 85, -1, 0, 24, 1, 1'b1};  // short frame
    tbl[2] = '{48,  40, 85, 20, 1, 48, 1, 1'b1};  // glitch inside frame
    tbl[3] = '{72,  10, 20, -1, 1, 72, 0, 1'b0};  // high exactly GLITCH_CYC counts
    tbl[4] = '{24, 199, 30, -1, 1, 24, 0, 1'b0};  // high one below stuck limit
    tbl[5] = '{23,  12, 20, -1, 0, 24, 1, 1'b1};  // MIN_BITS - 1
    tbl[6] = '{30,   9, 20, -1, 0, 24, 1, 1'b1};  // all glitches

    rst_i = 1'b1; bit_i = 1'b0; clr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pulse", int'(pulse_o), 0);
    chk("reset_bit_cnt", int'(bit_cnt_o), 0);
    chk("reset_err", int'(err_o), 0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);

    foreach (tbl[i]) begin
      n0 = n_pulse;
      send_frame(tbl[i].nbits, tbl[i].hi, tbl[i].lo, 600, tbl[i].glitch_at);
      chk($sformatf("row%0d_npulse", i), n_pulse - n0, tbl[i].exp_pulses);
      chk($sformatf("row%0d_bit_cnt", i), int'(bit_cnt_o), tbl[i].exp_cnt);
      chk($sformatf("row%0d_err", i), int'(err_o), tbl[i].exp_err);
      check_pulses($sformatf("row%0d", i));
      if (tbl[i].do_clr) begin
        do_clr();
        chk($sformatf("row%0d_clr", i), int'(err_o), 0);
      end
    end

    // Stuck high: error exactly HIGH_MAX_CYC + 2 posedges after the line rises.
    model_phase(1'b1, 500);
    bit_i = 1'b1;
    c = cyc;
    repeat (500) begin
      @(negedge clk);
      if (cyc == c + HIGH_MAX_CYC + 1) chk("stuck_err_before", int'(err_o), 0);
      if (cyc == c + HIGH_MAX_CYC + 2) chk("stuck_err_set", int'(err_o), 1);
    end
    phase(1'b0, 600);
    check_pulses("stuck_release");
    send_frame(24, 40, 60, 600, -1);
    check_pulses("after_stuck");
    do_clr();

    // Back-to-back frames with exactly RST_CYC low between them.
    n0 = n_pulse;
    for (int k = 0; k < 3; k++) send_frame(72, 12, 20, RST_CYC, -1);
    phase(1'b0, 100);
    chk("b2b_npulse", n_pulse - n0, 3);
    check_pulses("b2b");

    // Rise coinciding with frame end: first bit of the next frame is lost.
    send_frame(24, 20, 30, RST_CYC - 1, -1);
    send_frame(25, 20, 30, 600, -1);
    chk("edge_end_cnt", int'(bit_cnt_o), 24);
    check_pulses("edge_end");

    // Rise one cycle before frame end keeps the frame going.
    n0 = n_pulse;
    send_frame(24, 20, 30, RST_CYC - 2, -1);
    send_frame(25, 20, 30, 600, -1);
    chk("edge_cont_npulse", n_pulse - n0, 1);
    chk("edge_cont_cnt", int'(bit_cnt_o), 49);
    check_pulses("edge_cont");

    // Random frames, occasional glitches and clears.
    for (int f = 0; f < 6; f++) begin
      int nb, hi, lo;
      nb = int'($urandom_range(40, 10));
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(19, 0) == 0) hi = int'($urandom_range(9, 2));
        else                            hi = int'($urandom_range(50, 10));
        lo = int'($urandom_range(60, 10));
        phase(1'b1, hi);
        phase(1'b0, (i == nb - 1) ? int'($urandom_range(RST_CYC + 100, RST_CYC + 5)) : lo);
      end
      check_pulses($sformatf("rand%0d", f));
      if ($urandom_range(2, 0) == 0) do_clr();
    end

    // Clear in the same cycle an error is raised: error wins.
    do_clr();
    send_frame(8, 40, 85, 0, -1);
    model_phase(1'b0, 600);
    bit_i = 1'b0;
    c = cyc;
    repeat (600) begin
      @(negedge clk);
      clr_i = (cyc == c + RST_CYC + 1);
    end
    clr_i = 1'b0;
    chk("clr_vs_err", int'(err_o), 1);
    check_pulses("clr_vs_err");

    // Reset mid-frame discards the partial frame.
    send_frame(10, 40, 85, 30, -1);
    rst_i = 1'b1;
    #1;
    chk("midrst_pulse", int'(pulse_o), 0);
    chk("midrst_bit_cnt", int'(bit_cnt_o), 0);
    chk("midrst_err", int'(err_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    m_bits = 0; m_in = 1'b0; m_err = 1'b0; m_last = 0; m_drop = 1'b0;
    phase(1'b0, 50);
    send_frame(24, 40, 85, 600, -1);
    chk("midrst_resume_cnt", int'(bit_cnt_o), 24);
    check_pulses("midrst_resume");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
